// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: a bank of W registered set/reset flags shared by NREQ
// requesters through a round-robin arbiter. Each granted operation takes
// one IDLE cycle (arbitrate and capture) plus one APPLY cycle (write the
// flag), so the bank completes at most one operation every two clocks.
// The S=R=1 code is refused with an err pulse, so q/q_bar stay complementary.
//
// Requester handshake: a requester raises req with s_in/r_in/idx and holds
// all four stable until it sees its gnt bit; it drops req in the following
// (IDLE) cycle. A req still high in that cycle counts as a new request.
// Inputs are only looked at while IDLE.
module sr_flag_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDXW = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      s_in,
  input  logic [NREQ-1:0]      r_in,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic                 clr_all,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic [W-1:0]         q,
  output logic [W-1:0]         q_bar
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic            found;
  logic            op_s;
  logic            op_r;
  logic [IDXW-1:0] op_idx;
  logic            op_ok;
  logic [W-1:0]    q_next;

  // Round-robin winner: first active req searching upward from ptr+1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Captured op is legal when it is not S=R=1 and addresses an existing flag.
  always_comb begin
    op_ok = !(op_s && op_r) && (int'(op_idx) < W);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: IDLE -> APPLY on any request, APPLY always returns.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, pointer, op capture and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      ptr    <= PW'(NREQ - 1);
      op_s   <= 1'b0;
      op_r   <= 1'b0;
      op_idx <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      busy <= (state_next == APPLY);
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= NREQ'(1) << win;
            ptr    <= win;
            op_s   <= s_in[win];
            op_r   <= r_in[win];
            op_idx <= idx[int'(win)*IDXW +: IDXW];
          end else begin
            gnt <= '0;
          end
        end
        APPLY: begin
          gnt  <= '0;
          done <= op_ok;
          err  <= !op_ok;
        end
        default: gnt <= '0;
      endcase
    end
  end

  // Next flag bank: clr_all overrides any write landing on the same edge.
  always_comb begin
    q_next = q;
    if (clr_all) begin
      q_next = '0;
    end else if (state == APPLY && op_ok && (op_s || op_r)) begin
      q_next[op_idx] = op_s;
    end
  end

  // Flag bank and its complement share one edge so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      q_bar <= '1;
    end else begin
      q     <= q_next;
      q_bar <= ~q_next;
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter (NREQ=4, W=8, IDXW=3).
module tb_sr_flag_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDXW = 3;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      s_in;
  logic [NREQ-1:0]      r_in;
  logic [NREQ*IDXW-1:0] idx;
  logic                 clr_all;
  logic [NREQ-1:0]      gnt;
  logic                 done;
  logic                 err;
  logic                 busy;
  logic [W-1:0]         q;
  logic [W-1:0]         q_bar;

  int n_pass;
  int n_total;

  sr_flag_arbiter #(.NREQ(NREQ), .W(W), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .s_in(s_in), .r_in(r_in),
    .idx(idx), .clr_all(clr_all), .gnt(gnt), .done(done), .err(err),
    .busy(busy), .q(q), .q_bar(q_bar)
  );

  // Clock and run-time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drivers: inputs change only at negedges.
  task automatic drive_one(input int k, input logic s, input logic r, input int i);
    req                 = '0;
    req[k]              = 1'b1;
    s_in[k]             = s;
    r_in[k]             = r;
    idx[k*IDXW +: IDXW] = IDXW'(i);
  endtask

  // Full operation with no checks, used to build up bank contents.
  task automatic run_op(input int k, input logic s, input logic r, input int i);
    @(negedge clk);
    drive_one(k, s, r, i);
    @(negedge clk);
    req = '0;
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++;
      if ({q, q_bar, gnt, busy, done, err} !== {8'h00, 8'hFF, 4'b0000, 3'b000}) begin
        $display("FAIL reset_idle cyc%0d: got q=%h q_bar=%h gnt=%b busy=%b done=%b err=%b want 00 ff 0000 0 0 0",
                 c, q, q_bar, gnt, busy, done, err);
      end else n_pass++;
    end
  endtask

  task automatic test_single_set_reset;
    @(negedge clk);
    drive_one(1, 1'b1, 1'b0, 5);
    @(negedge clk);
    n_total++;
    if ({gnt, busy, done} !== {4'b0010, 1'b1, 1'b0}) begin
      $display("FAIL single_gnt: got gnt=%b busy=%b done=%b want 0010 1 0", gnt, busy, done);
    end else n_pass++;
    req = '0;
    @(negedge clk);
    n_total++;
    if ({q, q_bar, done, err, gnt, busy} !== {8'h20, 8'hDF, 1'b1, 1'b0, 4'b0000, 1'b0}) begin
      $display("FAIL single_set: got q=%h q_bar=%h done=%b err=%b gnt=%b busy=%b want 20 df 1 0 0000 0",
               q, q_bar, done, err, gnt, busy);
    end else n_pass++;
    drive_one(1, 1'b0, 1'b1, 5);
    @(negedge clk);
    n_total++;
    if (gnt !== 4'b0010) begin
      $display("FAIL single_rst_gnt: got %b want 0010", gnt);
    end else n_pass++;
    req = '0;
    @(negedge clk);
    n_total++;
    if ({q, q_bar, done} !== {8'h00, 8'hFF, 1'b1}) begin
      $display("FAIL single_rst: got q=%h q_bar=%h done=%b want 00 ff 1", q, q_bar, done);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if ({done, err} !== 2'b00) begin
      $display("FAIL single_pulse_len: got done=%b err=%b want 0 0", done, err);
    end else n_pass++;
  endtask

  task automatic test_invalid;
    run_op(2, 1'b1, 1'b0, 3);
    n_total++;
    if (q !== 8'h08) begin
      $display("FAIL invalid_setup: got q=%h want 08", q);
    end else n_pass++;
    drive_one(2, 1'b1, 1'b1, 3);
    @(negedge clk);
    n_total++;
    if (gnt !== 4'b0100) begin
      $display("FAIL invalid_gnt: got %b want 0100", gnt);
    end else n_pass++;
    req = '0;
    @(negedge clk);
    n_total++;
    if ({err, done, q, q_bar} !== {1'b1, 1'b0, 8'h08, 8'hF7}) begin
      $display("FAIL invalid_err: got err=%b done=%b q=%h q_bar=%h want 1 0 08 f7", err, done, q, q_bar);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if ({err, done, q} !== {1'b0, 1'b0, 8'h08}) begin
      $display("FAIL invalid_after: got err=%b done=%b q=%h want 0 0 08", err, done, q);
    end else n_pass++;
  endtask

  task automatic test_clr_all;
    // Clear while idle: bank clears, FSM untouched.
    @(negedge clk);
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    n_total++;
    if ({q, q_bar, busy, gnt, done} !== {8'h00, 8'hFF, 1'b0, 4'b0000, 1'b0}) begin
      $display("FAIL clr_idle: got q=%h q_bar=%h busy=%b gnt=%b done=%b want 00 ff 0 0000 0",
               q, q_bar, busy, gnt, done);
    end else n_pass++;
    for (int i = 0; i < 7; i++) run_op(0, 1'b1, 1'b0, i);
    n_total++;
    if (q !== 8'h7F) begin
      $display("FAIL clr_setup: got q=%h want 7f", q);
    end else n_pass++;
    drive_one(0, 1'b1, 1'b0, 7);
    @(negedge clk);
    n_total++;
    if (gnt !== 4'b0001) begin
      $display("FAIL clr_gnt: got %b want 0001", gnt);
    end else n_pass++;
    req     = '0;
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    n_total++;
    if ({q, q_bar, done, err} !== {8'h00, 8'hFF, 1'b1, 1'b0}) begin
      $display("FAIL clr_collide: got q=%h q_bar=%h done=%b err=%b want 00 ff 1 0", q, q_bar, done, err);
    end else n_pass++;
  endtask

  task automatic test_back_to_back;
    run_op(3, 1'b1, 1'b0, 2);
    drive_one(3, 1'b0, 1'b0, 2);
    @(negedge clk);
    n_total++;
    if (gnt !== 4'b1000) begin
      $display("FAIL noop_gnt: got %b want 1000", gnt);
    end else n_pass++;
    req = '0;
    @(negedge clk);
    n_total++;
    if ({done, err, q} !== {1'b1, 1'b0, 8'h04}) begin
      $display("FAIL noop_done: got done=%b err=%b q=%h want 1 0 04", done, err, q);
    end else n_pass++;
    // Requester 0 keeps req high through the IDLE cycle.
    drive_one(0, 1'b1, 1'b0, 1);
    @(negedge clk);
    n_total++;
    if ({busy, gnt} !== {1'b1, 4'b0001}) begin
      $display("FAIL b2b_first: got busy=%b gnt=%b want 1 0001", busy, gnt);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if ({busy, gnt, done, q} !== {1'b0, 4'b0000, 1'b1, 8'h06}) begin
      $display("FAIL b2b_idle: got busy=%b gnt=%b done=%b q=%h want 0 0000 1 06", busy, gnt, done, q);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if ({busy, gnt} !== {1'b1, 4'b0001}) begin
      $display("FAIL b2b_second: got busy=%b gnt=%b want 1 0001", busy, gnt);
    end else n_pass++;
    req = '0;
    @(negedge clk);
    n_total++;
    if ({busy, done} !== {1'b0, 1'b1}) begin
      $display("FAIL b2b_second_done: got busy=%b done=%b want 0 1", busy, done);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if ({busy, gnt, done} !== {1'b0, 4'b0000, 1'b0}) begin
      $display("FAIL b2b_quiet: got busy=%b gnt=%b done=%b want 0 0000 0", busy, gnt, done);
    end else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [W-1:0] exp_q;
    do_reset();
    @(negedge clk);
    req  = 4'b1111;
    s_in = 4'b1111;
    r_in = 4'b0000;
    for (int k = 0; k < NREQ; k++) idx[k*IDXW +: IDXW] = IDXW'(k);
    exp_q = 8'h00;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      n_total++;
      if ({gnt, busy} !== {4'(1 << (g % 4)), 1'b1}) begin
        $display("FAIL rr_gnt%0d: got gnt=%b busy=%b want %b 1", g, gnt, busy, 4'(1 << (g % 4)));
      end else n_pass++;
      exp_q[g % 4] = 1'b1;
      @(negedge clk);
      if (g == 4) req = '0;
      n_total++;
      if ({done, q} !== {1'b1, exp_q}) begin
        $display("FAIL rr_done%0d: got done=%b q=%h want 1 %h", g, done, q, exp_q);
      end else n_pass++;
    end
    n_total++;
    if ({q, q_bar} !== {8'h0F, 8'hF0}) begin
      $display("FAIL rr_final: got q=%h q_bar=%h want 0f f0", q, q_bar);
    end else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    run_op(1, 1'b1, 1'b0, 5);
    drive_one(1, 1'b1, 1'b0, 6);
    @(negedge clk);
    n_total++;
    if ({gnt, busy, q} !== {4'b0010, 1'b1, 8'h2F}) begin
      $display("FAIL mid_pre: got gnt=%b busy=%b q=%h want 0010 1 2f", gnt, busy, q);
    end else n_pass++;
    req   = '0;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({gnt, busy, done, err, q, q_bar} !== {4'b0000, 3'b000, 8'h00, 8'hFF}) begin
      $display("FAIL mid_reset: got gnt=%b busy=%b done=%b err=%b q=%h q_bar=%h want 0000 0 0 0 00 ff",
               gnt, busy, done, err, q, q_bar);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_total++;
      if ({done, err, busy, q} !== {3'b000, 8'h00}) begin
        $display("FAIL mid_discard: got done=%b err=%b busy=%b q=%h want 0 0 0 00", done, err, busy, q);
      end else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    req     = '0;
    s_in    = '0;
    r_in    = '0;
    idx     = '0;
    clr_all = 1'b0;
    test_reset();
    test_single_set_reset();
    test_invalid();
    test_clr_all();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
